// File: rtl/arcade_pkg.sv
// Shared definitions for the arcade input change reporter.
//
// Contents:
//   REPORT_HDR       - first byte of every report sent to the host
//   CMD_QUERY        - host command byte that requests the current input vector
//   report_state_e   - serializer FSM states
//   fifo_entry_t     - one pending report (vector, plus frame stamp when enabled)
//
// Build option:
//   INPUT_REPORTER_FRAME_STAMP_EN - when defined, each report carries a third byte
//                                   holding the low 8 bits of the USB frame number
//                                   captured when the report was queued.
package arcade_pkg;

    localparam logic [7:0] REPORT_HDR = 8'hA5;
    localparam logic [7:0] CMD_QUERY  = 8'h3F;

`ifdef INPUT_REPORTER_FRAME_STAMP_EN
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHdr   = 2'd1,
        StData  = 2'd2,
        StStamp = 2'd3
    } report_state_e;

    typedef struct packed {
        logic [7:0] vec;
        logic [7:0] stamp;
    } fifo_entry_t;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2
    } report_state_e;

    typedef struct packed {
        logic [7:0] vec;
    } fifo_entry_t;
`endif

endpackage

// File: rtl/debounce_cell.sv
// Single-input synchronizer and debouncer.
//
// The raw level passes through a two-flop synchronizer. The debounced level
// follows the synchronized level only after the two have disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement restarts the count.
//
// Ports:
//   clk_i    - application clock
//   rstn_i   - asynchronous active-low reset
//   raw_i    - raw asynchronous button level
//   level_o  - debounced level
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic raw_i,
    output logic level_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            // The cycle that completes the run flips the level and parks the counter at 0.
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/input_change_reporter.sv
// Arcade input change reporter.
//
// Debounces up to eight button inputs and reports the full debounced vector to
// the USB host whenever any bit changes, when the host sends the query command,
// and once each time the device becomes configured. Reports wait in a small FIFO;
// when it is full the newest entry is replaced so the host always ends up with
// the latest state. Each report is serialized as REPORT_HDR followed by the vector.
//
// Build option:
//   INPUT_REPORTER_FRAME_STAMP_EN - append frame_i[7:0], captured at enqueue, as a
//                                   third report byte.
//
// Ports:
//   clk_i            - application clock (12 MHz)
//   rstn_i           - asynchronous active-low reset
//   inputs_i         - raw button levels, 1 = pressed
//   frame_i          - USB frame number
//   usb_configured_i - USB device configured; low flushes and idles the reporter
//   out_data_i       - host-to-device byte
//   out_valid_i      - host-to-device byte valid
//   out_ready_o      - always ready once out of reset
//   in_data_o        - device-to-host byte
//   in_valid_o       - device-to-host byte valid
//   in_ready_i       - host accepts device-to-host byte
module input_change_reporter
    import arcade_pkg::*;
#(
    parameter int unsigned NUM_INPUTS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [NUM_INPUTS-1:0] inputs_i,
    input  logic [10:0]           frame_i,
    input  logic                  usb_configured_i,
    input  logic [7:0]            out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    output logic [7:0]            in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i
);

    // FIFO_DEPTH is a power of two and at least 2, so the head entry being sent is
    // never the newest entry that a coalescing push overwrites.
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] IdxLast = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Debouncing
    // ------------------------------------------------------------------
    logic [NUM_INPUTS-1:0] db_levels;
    logic [7:0]            db_vec;
    logic [7:0]            prev_vec_q;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .raw_i  (inputs_i[gi]),
            .level_o(db_levels[gi])
        );
    end

    always_comb begin
        db_vec                 = '0;
        db_vec[NUM_INPUTS-1:0] = db_levels;
    end

    // ------------------------------------------------------------------
    // Report triggers
    // ------------------------------------------------------------------
    logic ready_q;
    logic cfg_q;
    logic change_evt;
    logic query_evt;
    logic cfg_rise;
    logic push;

    assign out_ready_o = ready_q;
    // prev_vec_q lags db_vec by one cycle, so a change is queued the cycle after it lands.
    assign change_evt  = (db_vec != prev_vec_q);
    assign query_evt   = out_valid_i && ready_q && (out_data_i == CMD_QUERY);
    assign cfg_rise    = usb_configured_i && !cfg_q;
    // Simultaneous triggers collapse into one entry holding the current vector.
    assign push        = usb_configured_i && (change_evt || query_evt || cfg_rise);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ready_q    <= 1'b0;
            cfg_q      <= 1'b0;
            prev_vec_q <= '0;
        end else begin
            ready_q    <= 1'b1;
            cfg_q      <= usb_configured_i;
            prev_vec_q <= db_vec;
        end
    end

    // ------------------------------------------------------------------
    // Pending-report FIFO
    // ------------------------------------------------------------------
    fifo_entry_t   mem_q [FIFO_DEPTH];
    fifo_entry_t   new_entry;
    fifo_entry_t   head;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
        return (idx == IdxLast) ? '0 : idx + AW'(1);
    endfunction

    function automatic logic [AW-1:0] idx_dec(input logic [AW-1:0] idx);
        return (idx == '0) ? IdxLast : idx - AW'(1);
    endfunction

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_idx_q];

`ifdef INPUT_REPORTER_FRAME_STAMP_EN
    logic unused_frame;
    assign unused_frame    = ^frame_i[10:8];
    assign new_entry.vec   = db_vec;
    assign new_entry.stamp = frame_i[7:0];
`else
    logic unused_frame;
    assign unused_frame  = ^frame_i;
    assign new_entry.vec = db_vec;
`endif

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = wr_idx_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        count_d  = count_q;
        if (!usb_configured_i) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_idx_d = idx_inc(rd_idx_q);
            end
            if (push) begin
                wr_en = 1'b1;
                if (fifo_full && !pop) begin
                    // Coalesce: replace the newest entry instead of dropping the update.
                    wr_addr = idx_dec(wr_idx_q);
                end else begin
                    wr_idx_d = idx_inc(wr_idx_q);
                end
            end
            if (push && !pop && !fifo_full) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= new_entry;
        end
    end

    // ------------------------------------------------------------------
    // Report serializer
    // ------------------------------------------------------------------
    report_state_e state_q, state_d;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        in_valid_o = 1'b0;
        in_data_o  = 8'h00;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                in_valid_o = 1'b1;
                in_data_o  = REPORT_HDR;
                if (in_ready_i) begin
                    state_d = StData;
                end
            end
            StData: begin
                in_valid_o = 1'b1;
                in_data_o  = head.vec;
                if (in_ready_i) begin
`ifdef INPUT_REPORTER_FRAME_STAMP_EN
                    state_d = StStamp;
`else
                    state_d = StIdle;
                    pop     = 1'b1;
`endif
                end
            end
`ifdef INPUT_REPORTER_FRAME_STAMP_EN
            StStamp: begin
                in_valid_o = 1'b1;
                in_data_o  = head.stamp;
                if (in_ready_i) begin
                    state_d = StIdle;
                    pop     = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
        // Losing configuration abandons the report in flight; the FIFO flushes alongside.
        if (!usb_configured_i) begin
            state_d    = StIdle;
            pop        = 1'b0;
            in_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_input_change_reporter.sv
// Scoreboard bench for input_change_reporter. Stimulus pushes the bytes it
// expects into exp_q; the monitor pops and compares on every in_valid&in_ready.
// Debounce length is shortened to DEB; hold times scale with it (DEB for a
// qualifying press, DEB-1 for a glitch that must be rejected).
module tb_input_change_reporter;

    localparam int unsigned DEB = 120;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  inputs;
    logic [10:0] frame;
    logic        cfg;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    input_change_reporter #(
        .NUM_INPUTS     (8),
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .inputs_i        (inputs),
        .frame_i         (frame),
        .usb_configured_i(cfg),
        .out_data_i      (out_data),
        .out_valid_i     (out_valid),
        .out_ready_o     (out_ready),
        .in_data_o       (in_data),
        .in_valid_o      (in_valid),
        .in_ready_i      (in_ready)
    );

    // Monitor: every accepted device-to-host byte must match the scoreboard head.
    always @(negedge clk) begin
        if (rstn && in_valid && in_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %02h, none required", in_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (in_data !== exp_b) begin
                    bad++;
                    $display("FAIL report_byte: got %02h, required %02h", in_data, exp_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_report(input logic [7:0] vec);
        exp_q.push_back(8'hA5);
        exp_q.push_back(vec);
`ifdef INPUT_REPORTER_FRAME_STAMP_EN
        exp_q.push_back(frame[7:0]);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        out_data  = b;
        out_valid = 1'b1;
        cycles(1);
        out_valid = 1'b0;
        out_data  = 8'h00;
    endtask

    logic [7:0] burst [6];

    initial begin
        rstn      = 1'b0;
        inputs    = 8'h00;
        frame     = 11'h7AB;
        cfg       = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b0;
        in_ready  = 1'b1;
        #3;
        check("rst_in_valid", 32'(in_valid), 32'd0);
        check("rst_in_data", 32'(in_data), 32'h00);
        check("rst_out_ready", 32'(out_ready), 32'd0);
        cycles(3);
        rstn = 1'b1;
        cycles(2);
        check("out_ready_after_rst", 32'(out_ready), 32'd1);
        check("idle_unconfigured", 32'(in_valid), 32'd0);

        // Configuration rising reports the current vector once.
        cfg = 1'b1;
        expect_report(8'h00);
        cycles(12);
        check("drain_cfg_rise", 32'(exp_q.size()), 32'd0);

        // Glitch one cycle short of the debounce length is rejected.
        inputs = 8'h08;
        cycles(DEB - 1);
        inputs = 8'h00;
        cycles(DEB + 10);
        check("drain_glitch", 32'(exp_q.size()), 32'd0);
        expect_report(8'h00);
        send_byte(8'h3F);
        cycles(12);
        check("drain_glitch_query", 32'(exp_q.size()), 32'd0);

        // Qualifying press yields exactly one report.
        inputs = 8'h01;
        expect_report(8'h01);
        cycles(DEB + 20);
        check("drain_press", 32'(exp_q.size()), 32'd0);

        // Query with stable 0x81, then a non-query byte.
        inputs = 8'h81;
        expect_report(8'h81);
        cycles(DEB + 20);
        check("drain_to_81", 32'(exp_q.size()), 32'd0);
        expect_report(8'h81);
        send_byte(8'h3F);
        cycles(12);
        check("drain_query_81", 32'(exp_q.size()), 32'd0);
        send_byte(8'h41);
        cycles(20);
        check("drain_other_byte", 32'(exp_q.size()), 32'd0);

        // Host stalls: header held, then six changes coalesce into four reports.
        burst[0] = 8'h83; burst[1] = 8'h87; burst[2] = 8'h8F;
        burst[3] = 8'h9F; burst[4] = 8'hBF; burst[5] = 8'hFF;
        in_ready = 1'b0;
        frame    = 11'h055;
        inputs   = burst[0];
        cycles(DEB + 10);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("hdr_hold_valid", 32'(in_valid), 32'd1);
            check("hdr_hold_data", 32'(in_data), 32'hA5);
        end
        cycles(1);
        for (int i = 1; i < 6; i++) begin
            inputs = burst[i];
            cycles(DEB + 10);
        end
        expect_report(8'h83);
        expect_report(8'h87);
        expect_report(8'h8F);
        expect_report(8'hFF);
        in_ready = 1'b1;
        cycles(40);
        check("drain_coalesce", 32'(exp_q.size()), 32'd0);

        // Configuration dropped mid-report: abandon, flush, one report on re-raise.
        in_ready = 1'b0;
        send_byte(8'h3F);
        cycles(3);
        @(negedge clk);
        check("midreport_valid", 32'(in_valid), 32'd1);
        cycles(1);
        cfg = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_valid_next", 32'(in_valid), 32'd0);
        cycles(5);
        check("drop_valid_held", 32'(in_valid), 32'd0);
        in_ready = 1'b1;
        send_byte(8'h3F);
        cycles(5);
        check("drop_no_output", 32'(exp_q.size()), 32'd0);
        frame = 11'h123;
        cfg   = 1'b1;
        expect_report(8'hFF);
        cycles(20);
        check("drain_reraise", 32'(exp_q.size()), 32'd0);

        // Reset mid-transfer: nothing from the abandoned report reappears.
        in_ready = 1'b0;
        send_byte(8'h3F);
        cycles(3);
        rstn   = 1'b0;
        cfg    = 1'b0;
        inputs = 8'h00;
        #2;
        check("midrst_in_valid", 32'(in_valid), 32'd0);
        check("midrst_in_data", 32'(in_data), 32'h00);
        check("midrst_out_ready", 32'(out_ready), 32'd0);
        cycles(3);
        rstn = 1'b1;
        cycles(2);
        in_ready = 1'b1;
        cfg      = 1'b1;
        expect_report(8'h00);
        cycles(DEB + 20);
        check("drain_after_rst", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
